// File: rtl/alu_issue_seq.sv
// Operand/issue sequencer for a 6-bit ALU: register file, 3-cycle issue FSM
// (IDLE -> EXEC -> WB) and host load/readback ports.
module alu_issue_seq #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned REG_AW = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [4+3*REG_AW-1:0]   i_in_instr,
    input  logic                    i_wr_en,
    input  logic [REG_AW-1:0]       i_wr_addr,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic [REG_AW-1:0]       i_rd_addr,
    output logic [WIDTH-1:0]        o_rd_data,
    output logic [WIDTH-1:0]        o_alu_a,
    output logic [WIDTH-1:0]        o_alu_b,
    output logic [3:0]              o_alu_op,
    input  logic [WIDTH-1:0]        i_alu_y,
    output logic                    o_done,
    output logic [WIDTH-1:0]        o_result
);

    localparam int unsigned NREG = 1 << REG_AW;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWb
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [WIDTH-1:0]    r_rf [NREG];
    logic [REG_AW-1:0]   r_rd;
    logic [WIDTH-1:0]    r_alu_a;
    logic [WIDTH-1:0]    r_alu_b;
    logic [3:0]          r_alu_op;
    logic [WIDTH-1:0]    r_result;
    logic                r_done;

    logic [3:0]          w_op;
    logic [REG_AW-1:0]   w_rd;
    logic [REG_AW-1:0]   w_rs;
    logic [REG_AW-1:0]   w_rt;
    logic                w_accept;

    assign w_op = i_in_instr[3*REG_AW +: 4];
    assign w_rd = i_in_instr[2*REG_AW +: REG_AW];
    assign w_rs = i_in_instr[REG_AW +: REG_AW];
    assign w_rt = i_in_instr[0 +: REG_AW];

    assign o_in_ready = (r_state == StIdle);
    assign w_accept   = i_in_valid & o_in_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StExec;
            StExec:  w_state_d = StWb;
            StWb:    w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Writeback is assigned after the host write so it wins on an address collision.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
            r_rd     <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_rf[i_wr_addr] <= i_wr_data;
            end
            if (w_accept) begin
                r_rd     <= w_rd;
                r_alu_a  <= r_rf[w_rs];
                r_alu_b  <= r_rf[w_rt];
                r_alu_op <= w_op;
            end
            if (r_state == StExec) begin
                r_result <= i_alu_y;
                r_done   <= 1'b1;
            end
            if (r_state == StWb) begin
                r_rf[r_rd] <= r_result;
                r_done     <= 1'b0;
            end
        end
    end

    assign o_rd_data = r_rf[i_rd_addr];
    assign o_alu_a   = r_alu_a;
    assign o_alu_b   = r_alu_b;
    assign o_alu_op  = r_alu_op;
    assign o_result  = r_result;
    assign o_done    = r_done;

endmodule
